// File: rtl/mcpu_control_fsm_pkg.sv
// Shared definitions for the multi-cycle CPU control FSM: opcode/funct codes,
// ALU operation codes, datapath mux select encodings and state codes.
package mcpu_control_fsm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    localparam logic MEMIN_PC  = 1'b0;
    localparam logic MEMIN_ALU = 1'b1;
    localparam logic REGIN_MDR = 1'b0;
    localparam logic REGIN_ALU = 1'b1;

    localparam logic [1:0] DST_RD  = 2'd0;
    localparam logic [1:0] DST_RT  = 2'd1;
    localparam logic [1:0] DST_JAL = 2'd2;

    localparam logic [1:0] ASA_PC   = 2'd0;
    localparam logic [1:0] ASA_A    = 2'd1;
    localparam logic [1:0] ASA_BEN  = 2'd2;
    localparam logic [1:0] ASA_ZERO = 2'd3;

    localparam logic [1:0] ASB_IMM_SL2 = 2'd0;
    localparam logic [1:0] ASB_SEXT    = 2'd1;
    localparam logic [1:0] ASB_B       = 2'd2;
    localparam logic [1:0] ASB_FOUR    = 2'd3;

    localparam logic [1:0] PCSRC_BEN  = 2'd0;
    localparam logic [1:0] PCSRC_JUMP = 2'd1;
    localparam logic [1:0] PCSRC_ALU  = 2'd2;
    localparam logic [1:0] PCSRC_A    = 2'd3;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_WB_ALU   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_JR       = 4'd11,
        S_JAL      = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    // True when the opcode/funct pair is an instruction this controller executes.
    function automatic logic is_legal(input logic [5:0] opcode, input logic [5:0] funct);
        logic ok;
        ok = 1'b0;
        case (opcode)
            OP_RTYPE: ok = (funct == FN_ADD) || (funct == FN_SUB) ||
                           (funct == FN_SLT) || (funct == FN_JR);
            OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_XORI, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mcpu_control_fsm_alu_op_decoder.sv
// ALU operation select for the control FSM, decoded combinationally from the
// current state and the instruction fields held in IR.
module alu_op_decoder
    import mcpu_control_fsm_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op
);

    // Per-state ALU op; R-type and immediate ops consult the instruction fields.
    always_comb begin
        alu_op = ALU_ADD;
        case (state)
            S_EXEC_R: begin
                case (funct)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_EXEC_I: alu_op = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
            S_BRANCH: alu_op = ALU_SUB;
            default:  alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mcpu_control_fsm.sv
// Moore control FSM of the multi-cycle CPU; drives all datapath enables and
// mux selects. Optional macro ILLEGAL_TRAP_EN: unknown decodes enter a sticky
// HALT state with illegal=1 instead of retiring as a NOP.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// FETCH    | read IR from mem[PC], PC <= PC+4 (PC+4 also kept in alu_reg)
// DECODE   | load A/B, branch target into BEN, dispatch on opcode/funct
// EXEC_R   | R-type ALU op A,B
// EXEC_I   | immediate ALU op A,sext(imm)
// WB_ALU   | write alu_reg to rd (R) or rt (I)
// MEM_ADDR | effective address A+sext(imm)
// MEM_RD   | load read from mem[alu_reg]
// MEM_WB   | write MDR to rt
// MEM_WR   | store to mem[alu_reg]
// BRANCH   | compare A-B, take BEN on (BEQ & zero) | (BNE & ~zero)
// JUMP     | PC <= jump concat
// JR       | PC <= A
// JAL      | write PC+4 to JAL_REG, PC <= jump concat
// HALT     | trapped illegal instruction, everything idle until reset
module mcpu_control_fsm
    import mcpu_control_fsm_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int JAL_REG = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_we,
    output logic       ir_we,
    output logic       a_we,
    output logic       b_we,
    output logic       ben,
    output logic       mem_we,
    output logic       reg_we,
    output logic       memin,
    output logic       regin,
    output logic [1:0] dst,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alu_op,
    output logic       instr_done,
    output logic       illegal
);

    if (STATE_W != $bits(state_t)) begin : g_bad_state_w
        $error("STATE_W must equal the encoded state width");
    end
    if (JAL_REG > 31) begin : g_bad_jal_reg
        $error("JAL_REG must index one of 32 registers");
    end

    state_t     state;
    state_t     state_nxt;
    logic [1:0] dst_lat;
    logic [2:0] dec_alu_op;

    alu_op_decoder u_alu_op_decoder (
        .state  (state),
        .opcode (opcode),
        .funct  (funct),
        .alu_op (dec_alu_op)
    );

    // State register with synchronous active-low reset back to FETCH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Write-back destination chosen in the execute state, used by WB_ALU.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dst_lat <= DST_RD;
        end else if (state == S_EXEC_R) begin
            dst_lat <= DST_RD;
        end else if (state == S_EXEC_I) begin
            dst_lat <= DST_RT;
        end
    end

    // Next-state and Moore outputs; everything forced idle while reset is low.
    always_comb begin
        state_nxt  = state;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        a_we       = 1'b0;
        b_we       = 1'b0;
        ben        = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        memin      = MEMIN_PC;
        regin      = REGIN_MDR;
        dst        = DST_RD;
        alusrca    = ASA_PC;
        alusrcb    = ASB_IMM_SL2;
        pcsrc      = PCSRC_BEN;
        instr_done = 1'b0;

        case (state)
            S_FETCH: begin
                memin     = MEMIN_PC;
                ir_we     = 1'b1;
                alusrca   = ASA_PC;
                alusrcb   = ASB_FOUR;
                pcsrc     = PCSRC_ALU;
                pc_we     = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                a_we    = 1'b1;
                b_we    = 1'b1;
                ben     = 1'b1;
                alusrca = ASA_PC;
                alusrcb = ASB_IMM_SL2;
                if (!is_legal(opcode, funct)) begin
`ifdef ILLEGAL_TRAP_EN
                    state_nxt = S_HALT;
`else
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
`endif
                end else begin
                    case (opcode)
                        OP_RTYPE:        state_nxt = (funct == FN_JR) ? S_JR : S_EXEC_R;
                        OP_LW, OP_SW:    state_nxt = S_MEM_ADDR;
                        OP_ADDI, OP_XORI: state_nxt = S_EXEC_I;
                        OP_BEQ, OP_BNE:  state_nxt = S_BRANCH;
                        OP_J:            state_nxt = S_JUMP;
                        OP_JAL:          state_nxt = S_JAL;
                        default:         state_nxt = S_FETCH;
                    endcase
                end
            end
            S_EXEC_R: begin
                alusrca   = ASA_A;
                alusrcb   = ASB_B;
                state_nxt = S_WB_ALU;
            end
            S_EXEC_I: begin
                alusrca   = ASA_A;
                alusrcb   = ASB_SEXT;
                state_nxt = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_we     = 1'b1;
                regin      = REGIN_ALU;
                dst        = dst_lat;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEM_ADDR: begin
                alusrca   = ASA_A;
                alusrcb   = ASB_SEXT;
                state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                memin     = MEMIN_ALU;
                state_nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_we     = 1'b1;
                regin      = REGIN_MDR;
                dst        = DST_RT;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEM_WR: begin
                memin      = MEMIN_ALU;
                mem_we     = 1'b1;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = ASA_A;
                alusrcb    = ASB_B;
                pcsrc      = PCSRC_BEN;
                pc_we      = (opcode == OP_BEQ) ? zero : ~zero;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_JUMP: begin
                pcsrc      = PCSRC_JUMP;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_JR: begin
                pcsrc      = PCSRC_A;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_JAL: begin
                // alu_reg still holds PC+4 from FETCH; the ALU inputs are parked.
                alusrca    = ASA_PC;
                alusrcb    = ASB_FOUR;
                regin      = REGIN_ALU;
                dst        = DST_JAL;
                reg_we     = 1'b1;
                pcsrc      = PCSRC_JUMP;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
                state_nxt = S_HALT;
`else
                state_nxt = S_FETCH;
`endif
            end
            default: state_nxt = S_FETCH;
        endcase

        if (!reset) begin
            pc_we      = 1'b0;
            ir_we      = 1'b0;
            a_we       = 1'b0;
            b_we       = 1'b0;
            ben        = 1'b0;
            mem_we     = 1'b0;
            reg_we     = 1'b0;
            memin      = MEMIN_PC;
            regin      = REGIN_MDR;
            dst        = DST_RD;
            alusrca    = ASA_PC;
            alusrcb    = ASB_IMM_SL2;
            pcsrc      = PCSRC_BEN;
            instr_done = 1'b0;
        end
    end

    assign alu_op = reset ? dec_alu_op : ALU_ADD;

    // Illegal flag is the HALT state itself, so it is sticky until reset.
`ifdef ILLEGAL_TRAP_EN
    assign illegal = reset && (state == S_HALT);
`else
    assign illegal = 1'b0;
`endif

endmodule
